// File: rtl/cmp2_tracker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cmp2_tracker
// Purpose  : Sequential controller for a 2-bit magnitude comparator. On an
//            accepted start it latches the target onto B. It then steps the
//            position register (driven on A) by +/-1 per decision until the
//            comparator reports Eq. Inconsistent flags, running off the end
//            of the 2-bit range, or exceeding the step budget raise err.
// Ports    : clk            rising-edge clock
//            rst_n          asynchronous reset, active low
//            start          begin a run (sampled in IDLE, DONE, ERR)
//            target[1:0]    destination value, latched on accepted start
//            Eq, Gt, Lt     comparator flags (A==B, A>B, A<B)
//            A[1:0]         position register, to comparator A
//            B[1:0]         latched target, to comparator B
//            busy           high while in SETTLE or DECIDE
//            done           one-cycle pulse when position reaches target
//            err            sticky error, cleared by next accepted start
//            steps[2:0]     steps taken in current/last run
// Revision : 1.0 - initial release
// ============================================================================
module cmp2_tracker #(
    parameter int         SETTLE    = 1,
    parameter int         MAX_STEPS = 3,
    parameter logic [1:0] INIT_POS  = 2'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] target,
    input  logic       Eq,
    input  logic       Gt,
    input  logic       Lt,
    output logic [1:0] A,
    output logic [1:0] B,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] steps
);

    localparam int          CW          = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
    localparam logic [CW-1:0] c_settle  = CW'(SETTLE);
    localparam logic [2:0]  c_max_steps = 3'(MAX_STEPS);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_settle = 3'd1;
    localparam logic [2:0] c_st_decide = 3'd2;
    localparam logic [2:0] c_st_done   = 3'd3;
    localparam logic [2:0] c_st_err    = 3'd4;

    logic [2:0]    r_state;
    logic [1:0]    r_a;
    logic [1:0]    r_b;
    logic [2:0]    r_steps;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_done;
    logic          r_err;

    logic [2:0]    w_state_nxt;
    logic [1:0]    w_a_nxt;
    logic [1:0]    w_b_nxt;
    logic [2:0]    w_steps_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [2:0]    w_flags;

    assign w_flags = {Eq, Gt, Lt};

    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_steps_nxt = r_steps;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_st_idle, c_st_done, c_st_err: begin
                if (start) begin
                    w_state_nxt = c_st_settle;
                    w_b_nxt     = target;
                    w_steps_nxt = 3'd0;
                    w_cnt_nxt   = c_settle;
                end else if (r_state == c_st_done) begin
                    w_state_nxt = c_st_idle;
                end
            end
            c_st_settle: begin
                // Counter is loaded with SETTLE; leaving at 1 gives exactly SETTLE cycles here.
                if (r_cnt <= CW'(1)) begin
                    w_state_nxt = c_st_decide;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            c_st_decide: begin
                // A and steps are left untouched on every path into ERR.
                case (w_flags)
                    3'b100: w_state_nxt = c_st_done;
                    3'b001: begin
                        if (r_a == 2'd3 || r_steps == c_max_steps) begin
                            w_state_nxt = c_st_err;
                        end else begin
                            w_a_nxt     = r_a + 2'd1;
                            w_steps_nxt = r_steps + 3'd1;
                            w_cnt_nxt   = c_settle;
                            w_state_nxt = c_st_settle;
                        end
                    end
                    3'b010: begin
                        if (r_a == 2'd0 || r_steps == c_max_steps) begin
                            w_state_nxt = c_st_err;
                        end else begin
                            w_a_nxt     = r_a - 2'd1;
                            w_steps_nxt = r_steps + 3'd1;
                            w_cnt_nxt   = c_settle;
                            w_state_nxt = c_st_settle;
                        end
                    end
                    default: w_state_nxt = c_st_err;
                endcase
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    // Status flags are registered decodes of the next state so they line up
    // with the state register and carry no combinational path from inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_a     <= INIT_POS;
            r_b     <= 2'd0;
            r_steps <= 3'd0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_steps <= w_steps_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= (w_state_nxt == c_st_settle) || (w_state_nxt == c_st_decide);
            r_done  <= (w_state_nxt == c_st_done);
            r_err   <= (w_state_nxt == c_st_err);
        end
    end

    assign A     = r_a;
    assign B     = r_b;
    assign busy  = r_busy;
    assign done  = r_done;
    assign err   = r_err;
    assign steps = r_steps;

endmodule
`default_nettype wire

// File: tb/tb_cmp2_tracker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cmp2_tracker
// Purpose  : Self-checking bench. Two trackers (MAX_STEPS=3 and MAX_STEPS=1)
//            are each closed around a behavioural 2-bit comparator; the first
//            one's flags can be overridden to inject inconsistent values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmp2_tracker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       start0, eq0, gt0, lt0, busy0, done0, err0;
    logic [1:0] target0, a0, b0;
    logic [2:0] steps0;
    logic       ovr;
    logic [2:0] frc;

    logic       start1, eq1, gt1, lt1, busy1, done1, err1;
    logic [1:0] target1, a1, b1;
    logic [2:0] steps1;

    assign eq0 = ovr ? frc[2] : (a0 == b0);
    assign gt0 = ovr ? frc[1] : (a0 >  b0);
    assign lt0 = ovr ? frc[0] : (a0 <  b0);

    assign eq1 = (a1 == b1);
    assign gt1 = (a1 >  b1);
    assign lt1 = (a1 <  b1);

    cmp2_tracker #(.SETTLE(1), .MAX_STEPS(3), .INIT_POS(2'd0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .target(target0),
        .Eq(eq0), .Gt(gt0), .Lt(lt0), .A(a0), .B(b0),
        .busy(busy0), .done(done0), .err(err0), .steps(steps0)
    );

    cmp2_tracker #(.SETTLE(1), .MAX_STEPS(1), .INIT_POS(2'd0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .target(target1),
        .Eq(eq1), .Gt(gt1), .Lt(lt1), .A(a1), .B(b1),
        .busy(busy1), .done(done1), .err(err1), .steps(steps1)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Accept a start on DUT0, then count edges until done (-1 if it never comes).
    task automatic run0(input logic [1:0] tgt, output int lat);
        @(negedge clk);
        start0  = 1'b1;
        target0 = tgt;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        chk("busy_after_start", int'(busy0), 1);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done0) begin
                lat = i;
                break;
            end
        end
    endtask

    typedef struct {
        logic [1:0] target;
        int         lat;     // edges from accept edge to done
        logic [1:0] exp_a;
        int         exp_steps;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int seen_done;

        // SETTLE=1: each step and the final decision cost 2 edges each.
        vecs[0] = '{2'd3, 8, 2'd3, 3};   // 0 -> 3
        vecs[1] = '{2'd3, 2, 2'd3, 0};   // already there
        vecs[2] = '{2'd1, 6, 2'd1, 2};   // 3 -> 1
        vecs[3] = '{2'd0, 4, 2'd0, 1};   // 1 -> 0
        vecs[4] = '{2'd2, 6, 2'd2, 2};   // 0 -> 2

        ovr = 1'b0; frc = 3'b000;
        start0 = 1'b0; target0 = 2'd0;
        start1 = 1'b0; target1 = 2'd0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_A", int'(a0), 0);
        chk("rst_B", int'(b0), 0);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_done", int'(done0), 0);
        chk("rst_err", int'(err0), 0);
        chk("rst_steps", int'(steps0), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven runs, each starting from the previous final position.
        for (int i = 0; i < 5; i++) begin
            run0(vecs[i].target, lat);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_A", i), int'(a0), int'(vecs[i].exp_a));
            chk($sformatf("v%0d_B", i), int'(b0), int'(vecs[i].target));
            chk($sformatf("v%0d_steps", i), int'(steps0), vecs[i].exp_steps);
            chk($sformatf("v%0d_err", i), int'(err0), 0);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_done_pulse", i), int'(done0), 0);
            chk($sformatf("v%0d_idle_busy", i), int'(busy0), 0);
        end

        // Inconsistent flags (Eq and Gt together) from A=2 -> ERR, A frozen.
        ovr = 1'b1; frc = 3'b110;
        @(negedge clk);
        start0 = 1'b1; target0 = 2'd1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        lat = -1; seen_done = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done0) seen_done = 1;
            if (err0) begin
                lat = i;
                break;
            end
        end
        chk("fault_err_latency", lat, 2);
        chk("fault_no_done", seen_done, 0);
        chk("fault_A_frozen", int'(a0), 2);
        chk("fault_steps", int'(steps0), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("fault_err_sticky", int'(err0), 1);
        chk("fault_not_busy", int'(busy0), 0);
        ovr = 1'b0;
        @(negedge clk);
        start0 = 1'b1; target0 = 2'd2;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        chk("fault_err_cleared", int'(err0), 0);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done0) begin
                lat = i;
                break;
            end
        end
        chk("fault_recover_latency", lat, 2);

        // Return to 0, then reset in the middle of a 0 -> 3 run.
        run0(2'd0, lat);
        chk("home_latency", lat, 6);
        @(negedge clk);
        start0 = 1'b1; target0 = 2'd3;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        chk("midrst_busy_before", int'(busy0), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_A", int'(a0), 0);
        chk("midrst_B", int'(b0), 0);
        chk("midrst_busy", int'(busy0), 0);
        chk("midrst_done", int'(done0), 0);
        chk("midrst_err", int'(err0), 0);
        chk("midrst_steps", int'(steps0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run0(2'd1, lat);
        chk("postrst_latency", lat, 4);
        chk("postrst_A", int'(a0), 1);

        // MAX_STEPS=1 instance (also reset above, so A=0): 0 -> 2 needs two steps.
        @(negedge clk);
        start1 = 1'b1; target1 = 2'd2;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        lat = -1; seen_done = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done1) seen_done = 1;
            if (err1) begin
                lat = i;
                break;
            end
        end
        chk("maxstep_err_latency", lat, 4);
        chk("maxstep_no_done", seen_done, 0);
        chk("maxstep_A", int'(a1), 1);
        chk("maxstep_steps", int'(steps1), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
